bcd_time_counter: RTL and testbench



---
 rtl/bcd_time_counter.sv | 137 +++++++++++++
 tb/tb_bcd_time_counter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// hh:mm:ss BCD time source for the VGA clock display, with a 1 Hz prescaler and manual set mode.
// Define H12_MODE_EN for 12-hour counting (12,01..11) with an added pm output.
module bcd_time_counter #(
    parameter int TICK_DIV = 25000000,
    parameter int PRE_W    = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       set_en,
    input  logic [1:0] set_sel,
    input  logic       set_inc,
    output logic [3:0] h1,
    output logic [3:0] h0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       tick_1hz
`ifdef H12_MODE_EN
    ,
    output logic       pm
`endif
);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
`ifdef H12_MODE_EN
    localparam logic [7:0] HR_INIT = 8'h12;
`else
    localparam logic [7:0] HR_INIT = 8'h00;
`endif

    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       sec_q, min_q, hr_q;
    logic [7:0]       sec_d, min_d, hr_d;
    logic             wrap;
`ifdef H12_MODE_EN
    logic             pm_q, pm_d;
`endif

    // Each field is held as {tens, units} so BCD arithmetic stays per-nibble.
    function automatic logic [7:0] inc_60(input logic [7:0] v);
        if (v[3:0] != 4'd9)
            return {v[7:4], v[3:0] + 4'd1};
        if (v[7:4] == 4'd5)
            return 8'h00;
        return {v[7:4] + 4'd1, 4'd0};
    endfunction

    function automatic logic [7:0] inc_hours(input logic [7:0] v);
`ifdef H12_MODE_EN
        if (v == 8'h12)
            return 8'h01;
`else
        if (v == 8'h23)
            return 8'h00;
`endif
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign wrap = run && !set_en && (pre_cnt == PRE_MAX);

    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
`ifdef H12_MODE_EN
        pm_d  = pm_q;
`endif
        if (set_en) begin
            // Manual adjustment touches only the selected field; no carries.
            if (set_inc) begin
                case (set_sel)
                    2'd0: sec_d = inc_60(sec_q);
                    2'd1: min_d = inc_60(min_q);
                    2'd2: begin
                        hr_d = inc_hours(hr_q);
`ifdef H12_MODE_EN
                        pm_d = pm_q ^ (hr_q == 8'h11);
`endif
                    end
                    default: ;
                endcase
            end
        end else if (wrap) begin
            sec_d = inc_60(sec_q);
            if (sec_q == 8'h59) begin
                min_d = inc_60(min_q);
                if (min_q == 8'h59) begin
                    hr_d = inc_hours(hr_q);
`ifdef H12_MODE_EN
                    pm_d = pm_q ^ (hr_q == 8'h11);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt  <= '0;
            tick_1hz <= 1'b0;
            sec_q    <= 8'h00;
            min_q    <= 8'h00;
            hr_q     <= HR_INIT;
`ifdef H12_MODE_EN
            pm_q     <= 1'b0;
`endif
        end else begin
            if (set_en)
                pre_cnt <= '0;
            else if (run)
                pre_cnt <= wrap ? '0 : pre_cnt + PRE_ONE;
            tick_1hz <= wrap;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hr_q     <= hr_d;
`ifdef H12_MODE_EN
            pm_q     <= pm_d;
`endif
        end
    end

    assign h1 = hr_q[7:4];
    assign h0 = hr_q[3:0];
    assign m1 = min_q[7:4];
    assign m0 = min_q[3:0];
    assign s1 = sec_q[7:4];
    assign s0 = sec_q[3:0];
`ifdef H12_MODE_EN
    assign pm = pm_q;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed self-checking bench for bcd_time_counter in 24-hour mode with TICK_DIV = 4.
module tb_bcd_time_counter;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       set_en;
    logic [1:0] set_sel;
    logic       set_inc;
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       tick_1hz;
`ifdef H12_MODE_EN
    logic       pm;
`endif

    int checks = 0;
    int errors = 0;

    bcd_time_counter #(.TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .set_en   (set_en),
        .set_sel  (set_sel),
        .set_inc  (set_inc),
        .h1       (h1),
        .h0       (h0),
        .m1       (m1),
        .m0       (m0),
        .s1       (s1),
        .s0       (s0),
        .tick_1hz (tick_1hz)
`ifdef H12_MODE_EN
        ,
        .pm       (pm)
`endif
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold set_inc for n cycles in set mode on the chosen field.
    task automatic applyStimulus(input logic [1:0] sel, input int n);
        set_en  = 1'b1;
        set_sel = sel;
        set_inc = 1'b1;
        step(n);
        set_inc = 1'b0;
        set_sel = 2'd3;
    endtask

    task automatic checkOutput(input string tag, input logic [23:0] exp_time, input logic exp_tick);
        logic [23:0] obs;
        obs = {h1, h0, m1, m0, s1, s0};
        checks++;
        assert (obs === exp_time) else begin
            errors++;
            $error("[TB] FAIL %s time got %h expected %h", tag, obs, exp_time);
        end
        checks++;
        assert (tick_1hz === exp_tick) else begin
            errors++;
            $error("[TB] FAIL %s tick got %b expected %b", tag, tick_1hz, exp_tick);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; set_en = 1'b0; set_sel = 2'd3; set_inc = 1'b0;
        #1;
        checkOutput("reset_state", 24'h000000, 1'b0);
        step(2);
        rst = 1'b0;

        // Seconds carry 09 -> 10 and tick spacing.
        applyStimulus(2'd0, 9);
        checkOutput("set_sec_9", 24'h000009, 1'b0);
        applyStimulus(2'd3, 2);
        checkOutput("sel3_ignored", 24'h000009, 1'b0);
        set_en = 1'b0; run = 1'b1;
        step(3);
        checkOutput("before_first_tick", 24'h000009, 1'b0);
        step(1);
        checkOutput("sec_carry", 24'h000010, 1'b1);
        step(1);
        checkOutput("tick_one_cycle", 24'h000010, 1'b0);
        step(3);
        checkOutput("next_advance", 24'h000011, 1'b1);

        // Async reset mid-count at 10:20:30 -> 10:20:31 with tick high.
        applyStimulus(2'd2, 10);
        applyStimulus(2'd1, 20);
        applyStimulus(2'd0, 19);
        checkOutput("preset_102030", 24'h102030, 1'b0);
        set_en = 1'b0;
        step(4);
        checkOutput("advance_102031", 24'h102031, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset", 24'h000000, 1'b0);
        step(1);
        rst = 1'b0;

        // Full rollover 23:59:59 -> 00:00:00.
        applyStimulus(2'd2, 23);
        applyStimulus(2'd1, 59);
        applyStimulus(2'd0, 59);
        checkOutput("preset_235959", 24'h235959, 1'b0);
        set_en = 1'b0;
        step(3);
        checkOutput("pre_rollover", 24'h235959, 1'b0);
        step(1);
        checkOutput("full_rollover", 24'h000000, 1'b1);

        // Hold with run=0, resume from held prescaler value.
        applyStimulus(2'd2, 1);
        applyStimulus(2'd1, 2);
        applyStimulus(2'd0, 3);
        set_en = 1'b0;
        step(2);
        run = 1'b0;
        step(20);
        checkOutput("hold_20", 24'h010203, 1'b0);
        run = 1'b1;
        step(1);
        checkOutput("resume_1", 24'h010203, 1'b0);
        step(1);
        checkOutput("resume_advance", 24'h010204, 1'b1);

        // Set-mode field wraps without carry.
        applyStimulus(2'd2, 21);
        applyStimulus(2'd1, 57);
        applyStimulus(2'd0, 36);
        checkOutput("preset_225940", 24'h225940, 1'b0);
        applyStimulus(2'd2, 3);
        checkOutput("hour_set_wrap", 24'h015940, 1'b0);
        applyStimulus(2'd0, 25);
        checkOutput("sec_set_wrap", 24'h015905, 1'b0);
        applyStimulus(2'd1, 1);
        checkOutput("min_set_wrap", 24'h010005, 1'b0);

        // set_en raised while prescaler sits at TICK_DIV-1.
        set_en = 1'b0;
        step(3);
        set_en = 1'b1;
        step(1);
        checkOutput("set_wins_wrap", 24'h010005, 1'b0);
        set_en = 1'b0;
        step(3);
        checkOutput("after_set_wait", 24'h010005, 1'b0);
        step(1);
        checkOutput("after_set_advance", 24'h010006, 1'b1);
        set_sel = 2'd0; set_inc = 1'b1;
        step(1);
        set_inc = 1'b0; set_sel = 2'd3;
        checkOutput("inc_without_set", 24'h010006, 1'b0);

        // Hours units carry 09:59:59 -> 10:00:00.
        applyStimulus(2'd2, 8);
        applyStimulus(2'd1, 59);
        applyStimulus(2'd0, 53);
        checkOutput("preset_095959", 24'h095959, 1'b0);
        set_en = 1'b0;
        step(4);
        checkOutput("hour_units_carry", 24'h100000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
